instr_fetch_unit: RTL and testbench

Instruction fetch stage feeding the single-cycle processor core. Holds the program counter, issues word reads to instruction memory (fixed 1-cycle read latency), and buffers returned instructions with their PCs in a small FIFO. Presents them to decode/datapath over a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes all younger work.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush.
// Write-to-head latency 1 cycle; a push into a full FIFO is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    output fetch_entry_t head_dat_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          push_ok, pop_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
        push_ok = push_i & (~full | pop_i);
        pop_ok  = pop_i & ~empty_o;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok && !reset && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle instruction memory reads, buffered {pc, instr} output.
// Latency 2 cycles req->out_valid; issue is credit-limited so every response has a slot.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            pop, push;
    logic [OW-1:0]   occupancy;
    fetch_entry_t    head, push_dat;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        pop          = ~fifo_empty & out_ready;
        push         = inflight_q & ~redirect_valid;
        push_dat.pc  = req_pc_q;
        push_dat.instr = imem_rdata;
        // Entries held plus the one in flight, minus the slot freed by this cycle's pop.
        occupancy    = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
        imem_req     = ~reset & ~redirect_valid & (occupancy < OW'(FIFO_DEPTH));
        imem_addr    = fetch_pc_q;

        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        inflight_d   = imem_req;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            inflight_d = 1'b0;
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            req_pc_d   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_instr = fifo_empty ? '0 : head.instr;
    assign out_pc    = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle memory returning 0x13 + addr.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int checks = 0;
    int errors = 0;
    int nreq;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr + 32'h13) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_instr"}, out_instr, pc + 32'h13);
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;

        // Reset state
        next(); next(); #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);

        // Streaming with out_ready held high
        for (int k = 0; k < 6; k++) begin
            next();
            if (k == 0) reset = 1'b0;
            #1;
            chk_req("stream", 32'(4 * k));
            if (k < 2) chk("stream_novalid", {31'd0, out_valid}, 32'd0);
            else       chk_out("stream", 32'(4 * (k - 2)));
        end

        // Stall: fresh reset, out_ready low for 10 cycles
        next(); reset = 1'b1; out_ready = 1'b0;
        next();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            next();
            if (i == 0) reset = 1'b0;
            #1;
            if (imem_req) nreq++;
            if (i >= 2) chk_out("stall", 32'h0);
        end
        chk("stall_nreq", 32'(nreq), 32'd2);

        // Release: 0,4 drain and fetch resumes at 8
        next(); out_ready = 1'b1; #1;
        chk_out("rel0", 32'h0);  chk_req("rel0", 32'h8);
        next(); #1;
        chk_out("rel1", 32'h4);  chk_req("rel1", 32'hC);
        next(); #1;
        chk_out("rel2", 32'h8);  chk_req("rel2", 32'h10);
        next(); #1;
        chk_out("rel3", 32'hC);  chk_req("rel3", 32'h14);

        // Redirect to 0x100 with one entry buffered and one in flight
        next(); redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b0; #1;
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        chk_out("redir_head", 32'h10);
        next(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        chk("redir_b1", {31'd0, out_valid}, 32'd0);
        chk_req("redir_b1", 32'h100);
        next(); #1;
        chk("redir_b2", {31'd0, out_valid}, 32'd0);
        chk_req("redir_b2", 32'h104);
        next(); #1;
        chk_out("redir_t0", 32'h100);
        next(); #1;
        chk_out("redir_t1", 32'h104);

        // Misaligned redirect coincident with a pop
        next(); redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        chk_out("mis_pop", 32'h108);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        next(); redirect_valid = 1'b0; #1;
        chk("mis_b1", {31'd0, out_valid}, 32'd0);
        chk_req("mis_b1", 32'h100);
        next(); #1;
        chk("mis_b2", {31'd0, out_valid}, 32'd0);
        next(); #1;
        chk_out("mis_t0", 32'h100);

        // Redirect to the top of the address space: PC wraps to 0
        next(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk_out("wrap_pop", 32'h104);
        next(); redirect_valid = 1'b0; #1;
        chk_req("wrap_b1", 32'hFFFF_FFFC);
        next(); #1;
        chk_req("wrap_b2", 32'h0);
        next(); #1;
        chk_out("wrap_t0", 32'hFFFF_FFFC);
        next(); #1;
        chk_out("wrap_t1", 32'h0);

        // Reset mid-stream with an entry buffered and a request in flight
        next(); out_ready = 1'b0; reset = 1'b1; #1;
        chk_out("mrst_head", 32'h4);
        chk("mrst_req0", {31'd0, imem_req}, 32'd0);
        next(); #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_pc", out_pc, 32'h0);
        chk("mrst_addr", imem_addr, 32'h0);
        next(); reset = 1'b0; out_ready = 1'b1; #1;
        chk_req("mrst_r0", 32'h0);
        next(); #1;
        chk_req("mrst_r1", 32'h4);
        next(); #1;
        chk_out("mrst_t0", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
